// File: rtl/mem_axi_master_pkg.sv
// Shared types and constants for the MEM-stage AXI4-Lite data master.
package mem_axi_master_pkg;

    localparam int         AXI_DATA_W    = 64;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Transaction sequencer states; DONE is a one-cycle hold-off before IDLE.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_DONE    = 3'd5
    } axi_state_t;

    // Any response other than OKAY (SLVERR, DECERR, EXOKAY) is flagged to MEM.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/mem_axi_master.sv
// AXI4-Lite data-side master fed by the MEM stage ram_* request bundle.
// One AXI transaction per accepted request (write first when both are set),
// busy held through a one-cycle DONE state so MEM cannot re-issue while the
// pipeline stall is being released.
module mem_axi_master
    import mem_axi_master_pkg::*;
#(
    parameter  int ADDR_W = 64,
    parameter  int DATA_W = AXI_DATA_W,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ram_ren_i,
    input  logic              ram_wen_i,
    input  logic [ADDR_W-1:0] ram_raddr_i,
    input  logic [ADDR_W-1:0] ram_waddr_i,
    input  logic [DATA_W-1:0] ram_wdata_i,
    input  logic [DATA_W-1:0] ram_wmask_i,
    output logic [DATA_W-1:0] ram_rdata_o,
    output logic              axi_busy_o,
    output logic              done_o,
    output logic              err_o,

    output logic [ADDR_W-1:0] m_araddr_o,
    output logic              m_arvalid_o,
    input  logic              m_arready_i,

    input  logic [DATA_W-1:0] m_rdata_i,
    input  logic [1:0]        m_rresp_i,
    input  logic              m_rvalid_i,
    output logic              m_rready_o,

    output logic [ADDR_W-1:0] m_awaddr_o,
    output logic              m_awvalid_o,
    input  logic              m_awready_i,

    output logic [DATA_W-1:0] m_wdata_o,
    output logic [STRB_W-1:0] m_wstrb_o,
    output logic              m_wvalid_o,
    input  logic              m_wready_i,

    input  logic [1:0]        m_bresp_i,
    input  logic              m_bvalid_i,
    output logic              m_bready_o
);

    axi_state_t        state_reg;
    axi_state_t        state_next;

    logic [ADDR_W-1:0] raddr_reg;
    logic [ADDR_W-1:0] waddr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [STRB_W-1:0] wstrb_reg;
    logic [STRB_W-1:0] wstrb_next;
    logic [DATA_W-1:0] rdata_reg;
    logic              pend_rd_reg;
    logic              aw_done_reg;
    logic              w_done_reg;
    logic              err_reg;

    logic              accept_wr;
    logic              accept_rd;
    logic              aw_fire;
    logic              w_fire;

    // A byte lane is written if any bit of its mask byte is set.
    generate
        for (genvar gi = 0; gi < STRB_W; gi++) begin : g_strb
            assign wstrb_next[gi] = |ram_wmask_i[8*gi +: 8];
        end
    endgenerate

    assign accept_wr = (state_reg == ST_IDLE) && ram_wen_i;
    assign accept_rd = (state_reg == ST_IDLE) && ram_ren_i;
    assign aw_fire   = m_awvalid_o && m_awready_i;
    assign w_fire    = m_wvalid_o  && m_wready_i;

    // Payload comes only from captured registers, never straight from MEM.
    assign m_araddr_o  = raddr_reg;
    assign m_awaddr_o  = waddr_reg;
    assign m_wdata_o   = wdata_reg;
    assign m_wstrb_o   = wstrb_reg;
    assign ram_rdata_o = rdata_reg;

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Request capture, per-channel handshake tracking, response collection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            raddr_reg   <= '0;
            waddr_reg   <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            rdata_reg   <= '0;
            pend_rd_reg <= 1'b0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept_wr) begin
                        waddr_reg <= ram_waddr_i;
                        wdata_reg <= ram_wdata_i;
                        wstrb_reg <= wstrb_next;
                    end
                    if (accept_rd) begin
                        raddr_reg <= ram_raddr_i;
                    end
                    if (accept_wr || accept_rd) begin
                        pend_rd_reg <= accept_wr && accept_rd;
                        aw_done_reg <= 1'b0;
                        w_done_reg  <= 1'b0;
                        err_reg     <= 1'b0;
                    end
                end
                ST_WR_REQ: begin
                    if (aw_fire) begin
                        aw_done_reg <= 1'b1;
                    end
                    if (w_fire) begin
                        w_done_reg <= 1'b1;
                    end
                end
                ST_WR_RESP: begin
                    if (m_bvalid_i) begin
                        pend_rd_reg <= 1'b0;
                        if (resp_is_err(m_bresp_i)) begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (m_rvalid_i) begin
                        rdata_reg <= m_rdata_i;
                        if (resp_is_err(m_rresp_i)) begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and state-decoded AXI/pipeline outputs.
    always_comb begin
        state_next  = state_reg;
        m_arvalid_o = 1'b0;
        m_rready_o  = 1'b0;
        m_awvalid_o = 1'b0;
        m_wvalid_o  = 1'b0;
        m_bready_o  = 1'b0;
        axi_busy_o  = (state_reg != ST_IDLE);
        done_o      = 1'b0;
        err_o       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (ram_wen_i) begin
                    state_next = ST_WR_REQ;
                end else if (ram_ren_i) begin
                    state_next = ST_RD_ADDR;
                end
            end
            ST_WR_REQ: begin
                // AW and W are independent; each valid stays up until its own handshake.
                m_awvalid_o = !aw_done_reg;
                m_wvalid_o  = !w_done_reg;
                if ((aw_done_reg || m_awready_i) && (w_done_reg || m_wready_i)) begin
                    state_next = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                m_bready_o = 1'b1;
                if (m_bvalid_i) begin
                    state_next = pend_rd_reg ? ST_RD_ADDR : ST_DONE;
                end
            end
            ST_RD_ADDR: begin
                m_arvalid_o = 1'b1;
                if (m_arready_i) begin
                    state_next = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                m_rready_o = 1'b1;
                if (m_rvalid_i) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // Request inputs are deliberately ignored here.
                done_o     = 1'b1;
                err_o      = err_reg;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_axi_master.sv
// Directed bench for mem_axi_master with a latency-configurable AXI4-Lite slave.
`timescale 1ns/1ps
module tb_mem_axi_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ram_ren_i = 1'b0, ram_wen_i = 1'b0;
    logic [63:0] ram_raddr_i = '0, ram_waddr_i = '0, ram_wdata_i = '0, ram_wmask_i = '0;
    logic [63:0] ram_rdata_o;
    logic        axi_busy_o, done_o, err_o;
    logic [63:0] m_araddr_o, m_awaddr_o, m_wdata_o;
    logic        m_arvalid_o, m_rready_o, m_awvalid_o, m_wvalid_o, m_bready_o;
    logic [7:0]  m_wstrb_o;
    logic        m_arready_i = 1'b0, m_rvalid_i = 1'b0, m_awready_i = 1'b0;
    logic        m_wready_i = 1'b0, m_bvalid_i = 1'b0;
    logic [63:0] m_rdata_i = '0;
    logic [1:0]  m_rresp_i = '0, m_bresp_i = '0;

    always #5 clk = ~clk;

    mem_axi_master #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .ram_ren_i(ram_ren_i), .ram_wen_i(ram_wen_i),
        .ram_raddr_i(ram_raddr_i), .ram_waddr_i(ram_waddr_i),
        .ram_wdata_i(ram_wdata_i), .ram_wmask_i(ram_wmask_i),
        .ram_rdata_o(ram_rdata_o), .axi_busy_o(axi_busy_o),
        .done_o(done_o), .err_o(err_o),
        .m_araddr_o(m_araddr_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
        .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
        .m_awaddr_o(m_awaddr_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
        .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
        .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Slave configuration: per-channel wait cycles after valid/ready seen.
    int          aw_lat = 0, w_lat = 0, ar_lat = 0, r_lat = 0, b_lat = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [63:0] rdata_cfg = '0;

    // Slave observation counters.
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0, b_cnt = 0;
    int          aw_cyc = 0, w_cyc = 0, ar_cyc = 0, aw_hs = 0, w_hs = 0, ar_hs = 0;
    int          done_cnt = 0, cyc = 0, b_hs_cyc = -1, ar_first_cyc = -1;
    logic [63:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
    logic [7:0]  cap_wstrb = '0;

    // Slave drives on the falling edge; valid seen now plus ready driven now
    // is exactly the handshake the DUT sees at the next rising edge.
    always @(negedge clk) begin
        cyc++;
        if (m_awvalid_o) begin
            m_awready_i = (aw_cnt >= aw_lat); aw_cnt++; aw_cyc++;
            if (m_awready_i) begin aw_hs++; cap_awaddr = m_awaddr_o; end
        end else begin
            m_awready_i = 1'b0; aw_cnt = 0;
        end
        if (m_wvalid_o) begin
            m_wready_i = (w_cnt >= w_lat); w_cnt++; w_cyc++;
            if (m_wready_i) begin w_hs++; cap_wdata = m_wdata_o; cap_wstrb = m_wstrb_o; end
        end else begin
            m_wready_i = 1'b0; w_cnt = 0;
        end
        if (m_bready_o) begin
            m_bvalid_i = (b_cnt >= b_lat); b_cnt++;
            m_bresp_i  = m_bvalid_i ? bresp_cfg : 2'b00;
            if (m_bvalid_i) b_hs_cyc = cyc;
        end else begin
            m_bvalid_i = 1'b0; b_cnt = 0; m_bresp_i = 2'b00;
        end
        if (m_arvalid_o) begin
            if (ar_first_cyc < 0) ar_first_cyc = cyc;
            m_arready_i = (ar_cnt >= ar_lat); ar_cnt++; ar_cyc++;
            if (m_arready_i) begin ar_hs++; cap_araddr = m_araddr_o; end
        end else begin
            m_arready_i = 1'b0; ar_cnt = 0;
        end
        if (m_rready_o) begin
            m_rvalid_i = (r_cnt >= r_lat); r_cnt++;
            m_rdata_i  = m_rvalid_i ? rdata_cfg : 64'h0;
            m_rresp_i  = m_rvalid_i ? rresp_cfg : 2'b00;
        end else begin
            m_rvalid_i = 1'b0; r_cnt = 0; m_rdata_i = '0; m_rresp_i = 2'b00;
        end
        if (done_o) done_cnt++;
    end

    task automatic clr_stats();
        aw_cyc = 0; w_cyc = 0; ar_cyc = 0; aw_hs = 0; w_hs = 0; ar_hs = 0;
        done_cnt = 0; b_hs_cyc = -1; ar_first_cyc = -1;
    endtask

    // Issue one request and wait (bounded) for done_o. edges counts rising
    // edges from acceptance to DONE. Inputs are scrambled after acceptance
    // unless hold is set (stalled MEM keeps its request up through DONE).
    task automatic run_req(input logic r, input logic w, input logic [63:0] ra,
                           input logic [63:0] wa, input logic [63:0] wd, input logic [63:0] wm,
                           input logic hold, output int edges, output logic err_seen,
                           output logic busy_ok, output logic busy_after, output logic done_after);
        clr_stats();
        @(negedge clk);
        ram_ren_i = r; ram_wen_i = w; ram_raddr_i = ra; ram_waddr_i = wa;
        ram_wdata_i = wd; ram_wmask_i = wm;
        edges = 0; err_seen = 1'b0; busy_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (!hold) begin
                ram_ren_i = 1'b0; ram_wen_i = 1'b0;
                ram_raddr_i = ~ra; ram_waddr_i = ~wa; ram_wdata_i = ~wd; ram_wmask_i = ~wm;
            end
            if (!axi_busy_o) busy_ok = 1'b0;
            if (done_o) begin err_seen = err_o; break; end
        end
        check_val("done_seen", {63'h0, done_o}, 64'h1);
        @(negedge clk);
        busy_after = axi_busy_o; done_after = done_o;
        ram_ren_i = 1'b0; ram_wen_i = 1'b0;
    endtask

    int   edges;
    logic err_seen, busy_ok, busy_after, done_after;

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_busy",  {63'h0, axi_busy_o}, 64'h0);
        check_val("rst_done_err", {62'h0, done_o, err_o}, 64'h0);
        check_val("rst_valids", {59'h0, m_arvalid_o, m_awvalid_o, m_wvalid_o, m_rready_o, m_bready_o}, 64'h0);
        check_val("rst_rdata", ram_rdata_o, 64'h0);
        check_val("rst_wstrb", {56'h0, m_wstrb_o}, 64'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Read, zero-wait slave
        rdata_cfg = 64'h1122_3344_5566_7788;
        run_req(1'b1, 1'b0, 64'h8000_0010, '0, '0, '0, 1'b0, edges, err_seen, busy_ok, busy_after, done_after);
        check_val("rd_edges", edges, 3);
        check_val("rd_rdata", ram_rdata_o, 64'h1122_3344_5566_7788);
        check_val("rd_araddr", cap_araddr, 64'h8000_0010);
        check_val("rd_ar_cycles", ar_cyc, 1);
        check_val("rd_err", {63'h0, err_seen}, 64'h0);
        check_val("rd_busy", {62'h0, busy_ok, busy_after}, 64'h2);
        check_val("rd_done_cnt", done_cnt, 1);

        // Write, awready two cycles late, wready immediate
        aw_lat = 2;
        run_req(1'b0, 1'b1, '0, 64'h8000_0040, 64'hA5A5_0000_1234_5678, 64'h0000_0000_0000_ffff,
                1'b0, edges, err_seen, busy_ok, busy_after, done_after);
        check_val("wr_edges", edges, 5);
        check_val("wr_wstrb", {56'h0, cap_wstrb}, 64'h03);
        check_val("wr_w_cycles", w_cyc, 1);
        check_val("wr_aw_cycles", aw_cyc, 3);
        check_val("wr_awaddr", cap_awaddr, 64'h8000_0040);
        check_val("wr_wdata", cap_wdata, 64'hA5A5_0000_1234_5678);
        check_val("wr_busy", {62'h0, busy_ok, busy_after}, 64'h2);
        check_val("wr_err", {63'h0, err_seen}, 64'h0);
        aw_lat = 0;

        // Simultaneous write + read at the same address
        rdata_cfg = 64'h0BAD_F00D_CAFE_0001;
        run_req(1'b1, 1'b1, 64'h8000_0100, 64'h8000_0100, 64'hFEED_0000_0000_BEEF, '1,
                1'b0, edges, err_seen, busy_ok, busy_after, done_after);
        check_val("wr_rd_edges", edges, 5);
        check_val("wr_rd_done_cnt", done_cnt, 1);
        check_val("wr_rd_b_before_ar", {63'h0, (b_hs_cyc >= 0) && (b_hs_cyc < ar_first_cyc)}, 64'h1);
        check_val("wr_rd_rdata", ram_rdata_o, 64'h0BAD_F00D_CAFE_0001);
        check_val("wr_rd_addrs", {cap_awaddr[31:0], cap_araddr[31:0]}, 64'h8000_0100_8000_0100);
        check_val("wr_rd_wstrb", {56'h0, cap_wstrb}, 64'hff);

        // SLVERR on B, sparse mask; next transaction is clean
        bresp_cfg = 2'b10;
        run_req(1'b0, 1'b1, '0, 64'h8000_0200, 64'h1, 64'h00ff_0000_0001_0000,
                1'b0, edges, err_seen, busy_ok, busy_after, done_after);
        check_val("bresp_err", {63'h0, err_seen}, 64'h1);
        check_val("sparse_wstrb", {56'h0, cap_wstrb}, 64'h44);
        bresp_cfg = 2'b00;
        run_req(1'b1, 1'b0, 64'h8000_0300, '0, '0, '0, 1'b0, edges, err_seen, busy_ok, busy_after, done_after);
        check_val("err_cleared", {63'h0, err_seen}, 64'h0);

        // Error on R
        rresp_cfg = 2'b11;
        run_req(1'b1, 1'b0, 64'h8000_0308, '0, '0, '0, 1'b0, edges, err_seen, busy_ok, busy_after, done_after);
        check_val("rresp_err", {63'h0, err_seen}, 64'h1);
        rresp_cfg = 2'b00;

        // Zero mask still issues the write
        run_req(1'b0, 1'b1, '0, 64'h8000_0400, 64'h55, 64'h0, 1'b0, edges, err_seen, busy_ok, busy_after, done_after);
        check_val("zmask_hs", {aw_hs[31:0], w_hs[31:0]}, {32'd1, 32'd1});
        check_val("zmask_wstrb", {56'h0, cap_wstrb}, 64'h0);

        // ren held through DONE: one AR only, IDLE after DONE
        rdata_cfg = 64'h7777_6666_5555_4444;
        run_req(1'b1, 1'b0, 64'h8000_0500, '0, '0, '0, 1'b1, edges, err_seen, busy_ok, busy_after, done_after);
        check_val("hold_ar_hs", ar_hs, 1);
        check_val("hold_idle_after", {62'h0, busy_after, done_after}, 64'h0);
        check_val("hold_done_cnt", done_cnt, 1);
        check_val("hold_rdata", ram_rdata_o, 64'h7777_6666_5555_4444);

        // Reset in RD_DATA with rvalid pending
        r_lat = 3;
        @(negedge clk);
        ram_ren_i = 1'b1; ram_raddr_i = 64'h8000_0600;
        @(negedge clk);
        ram_ren_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (m_rvalid_i) break;
        end
        check_val("rst_mid_rvalid_pending", {62'h0, m_rvalid_i, m_rready_o}, 64'h3);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check_val("rst_mid_busy_done", {62'h0, axi_busy_o, done_o}, 64'h0);
        check_val("rst_mid_valids", {59'h0, m_arvalid_o, m_awvalid_o, m_wvalid_o, m_rready_o, m_bready_o}, 64'h0);
        check_val("rst_mid_rdata", ram_rdata_o, 64'h0);
        rst = 1'b1;
        r_lat = 0;
        rdata_cfg = 64'hDEAD_BEEF_0BAD_F00D;
        run_req(1'b1, 1'b0, 64'h8000_0700, '0, '0, '0, 1'b0, edges, err_seen, busy_ok, busy_after, done_after);
        check_val("post_rst_edges", edges, 3);
        check_val("post_rst_rdata", ram_rdata_o, 64'hDEAD_BEEF_0BAD_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
